// File: rtl/pkt_meta_align.sv
// Pairs each packet with one metadata word and forwards it through a single
// registered output stage; non-sop beats without metadata and oversize tails are dropped.
package pkt_meta_align_pkg;
    typedef struct packed {
        logic [15:0] flow_id;
        logic [15:0] pkt_len;
        logic [31:0] tag;
    } metadata_t;
endpackage

module pkt_meta_align
    import pkt_meta_align_pkg::*;
#(
    parameter logic [1:0]  CHANNEL_ID = 2'd0,
    parameter int unsigned MAX_BEATS  = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  metadata_t    in_meta_data,
    input  logic         in_meta_valid,
    output logic         in_meta_ready,
    input  logic [511:0] in_pkt_data,
    input  logic         in_pkt_valid,
    input  logic         in_pkt_sop,
    input  logic         in_pkt_eop,
    input  logic [5:0]   in_pkt_empty,
    output logic         in_pkt_ready,
    output logic [511:0] out_pkt_data,
    output logic         out_pkt_valid,
    output logic         out_pkt_sop,
    output logic         out_pkt_eop,
    output logic [5:0]   out_pkt_empty,
    output logic [1:0]   out_pkt_channel,
    input  logic         out_pkt_ready,
    output metadata_t    out_meta_data,
    output logic         out_meta_valid,
    output logic [31:0]  orphan_cnt,
    output logic [31:0]  oversize_cnt,
    output logic [31:0]  pkt_cnt
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

    state_t     state, state_nxt;
    metadata_t  meta_q;
    logic [15:0] beat_cnt;
    logic       stage_free;
    logic       meta_fire;
    logic       beat_fire;
    logic       eop_beat;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign out_pkt_channel = CHANNEL_ID;
    assign stage_free      = !out_pkt_valid || out_pkt_ready;
    assign meta_fire       = in_meta_valid && in_meta_ready;
    assign beat_fire       = in_pkt_valid && in_pkt_ready;
    assign eop_beat        = in_pkt_eop || (beat_cnt == LAST_BEAT);

    always_comb begin
        state_nxt     = state;
        in_meta_ready = 1'b0;
        in_pkt_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                // A sop beat waits here until its metadata has been taken.
                in_meta_ready = 1'b1;
                in_pkt_ready  = !in_pkt_sop;
                if (in_meta_valid) state_nxt = FWD;
            end
            FWD: begin
                in_pkt_ready = stage_free;
                if (in_pkt_valid && stage_free && eop_beat)
                    state_nxt = in_pkt_eop ? IDLE : DROP;
            end
            DROP: begin
                in_pkt_ready = 1'b1;
                if (in_pkt_valid && in_pkt_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // NOTE: handshakes are gated by reset so nothing is consumed while state is being cleared.
        if (!rst_n) begin
            in_meta_ready = 1'b0;
            in_pkt_ready  = 1'b0;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            meta_q         <= '0;
            beat_cnt       <= '0;
            out_pkt_data   <= '0;
            out_pkt_valid  <= 1'b0;
            out_pkt_sop    <= 1'b0;
            out_pkt_eop    <= 1'b0;
            out_pkt_empty  <= '0;
            out_meta_data  <= '0;
            out_meta_valid <= 1'b0;
            orphan_cnt     <= '0;
            oversize_cnt   <= '0;
            pkt_cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (meta_fire) begin
                meta_q   <= in_meta_data;
                beat_cnt <= '0;
            end
            if (state == IDLE && beat_fire)
                orphan_cnt <= sat_inc(orphan_cnt);

            if (state == FWD && beat_fire) begin
                out_pkt_data   <= in_pkt_data;
                out_pkt_valid  <= 1'b1;
                out_pkt_sop    <= (beat_cnt == '0);
                out_pkt_eop    <= eop_beat;
                out_pkt_empty  <= in_pkt_eop ? in_pkt_empty : (eop_beat ? 6'd0 : in_pkt_empty);
                out_meta_data  <= meta_q;
                out_meta_valid <= (beat_cnt == '0);
                beat_cnt       <= beat_cnt + 16'd1;
                if (eop_beat) begin
                    pkt_cnt <= sat_inc(pkt_cnt);
                    if (!in_pkt_eop) oversize_cnt <= sat_inc(oversize_cnt);
                end
            end else if (out_pkt_ready) begin
                out_pkt_valid  <= 1'b0;
                out_meta_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pkt_meta_align.sv
// Directed bench for pkt_meta_align: forwarding, orphans, oversize truncation,
// back-pressure, mid-packet reset and same-cycle meta/sop arrival.
module tb_pkt_meta_align;
    import pkt_meta_align_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    metadata_t    in_meta_data;
    logic         in_meta_valid;
    logic         in_meta_ready;
    logic [511:0] in_pkt_data;
    logic         in_pkt_valid, in_pkt_sop, in_pkt_eop;
    logic [5:0]   in_pkt_empty;
    logic         in_pkt_ready;
    logic [511:0] out_pkt_data;
    logic         out_pkt_valid, out_pkt_sop, out_pkt_eop;
    logic [5:0]   out_pkt_empty;
    logic [1:0]   out_pkt_channel;
    logic         out_pkt_ready;
    metadata_t    out_meta_data;
    logic         out_meta_valid;
    logic [31:0]  orphan_cnt, oversize_cnt, pkt_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    localparam metadata_t M1 = '{flow_id: 16'h1111, pkt_len: 16'd3,  tag: 32'hA5A5_0001};
    localparam metadata_t M2 = '{flow_id: 16'h2222, pkt_len: 16'd3,  tag: 32'hA5A5_0002};
    localparam metadata_t M3 = '{flow_id: 16'h3333, pkt_len: 16'd6,  tag: 32'hA5A5_0003};
    localparam metadata_t M4 = '{flow_id: 16'h4444, pkt_len: 16'd4,  tag: 32'hA5A5_0004};
    localparam metadata_t M5 = '{flow_id: 16'h5555, pkt_len: 16'd2,  tag: 32'hA5A5_0005};

    pkt_meta_align #(.CHANNEL_ID(2'd2), .MAX_BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
        .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_sop(in_pkt_sop),
        .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
        .out_pkt_data(out_pkt_data), .out_pkt_valid(out_pkt_valid), .out_pkt_sop(out_pkt_sop),
        .out_pkt_eop(out_pkt_eop), .out_pkt_empty(out_pkt_empty), .out_pkt_channel(out_pkt_channel),
        .out_pkt_ready(out_pkt_ready), .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid),
        .orphan_cnt(orphan_cnt), .oversize_cnt(oversize_cnt), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mk(input int n);
        logic [31:0] w;
        w = 32'(n);
        return {16{w}};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic beat(input logic v, input logic s, input logic e, input logic [5:0] emp,
                        input logic [511:0] d);
        in_pkt_valid = v;
        in_pkt_sop   = s;
        in_pkt_eop   = e;
        in_pkt_empty = emp;
        in_pkt_data  = d;
    endtask

    task automatic meta(input logic v, input metadata_t m);
        in_meta_valid = v;
        in_meta_data  = m;
    endtask

    initial begin
        rst_n = 1'b0;
        out_pkt_ready = 1'b1;
        meta(1'b0, '0);
        beat(1'b1, 1'b0, 1'b0, 6'd0, mk(99));
        tick();
        tick();
        // ---- reset state ----
        check("rst_valid",     out_pkt_valid, 1'b0);
        check("rst_meta_vld",  out_meta_valid, 1'b0);
        check("rst_data",      out_pkt_data, '0);
        check("rst_pkt_cnt",   pkt_cnt, 32'd0);
        check("rst_orphan",    orphan_cnt, 32'd0);
        check("rst_channel",   out_pkt_channel, 2'd2);
        check("rst_pkt_rdy",   in_pkt_ready, 1'b0);
        check("rst_meta_rdy",  in_meta_ready, 1'b0);

        // ---- basic 3-beat packet ----
        rst_n = 1'b1;
        beat(1'b0, 1'b0, 1'b0, 6'd0, '0);
        meta(1'b1, M1);
        settle();
        check("idle_meta_rdy", in_meta_ready, 1'b1);
        tick();
        meta(1'b0, '0);
        beat(1'b1, 1'b1, 1'b0, 6'd0, mk(1));
        settle();
        check("fwd_pkt_rdy",   in_pkt_ready, 1'b1);
        check("fwd_meta_rdy",  in_meta_ready, 1'b0);
        tick();
        check("b1_valid",      out_pkt_valid, 1'b1);
        check("b1_sop",        out_pkt_sop, 1'b1);
        check("b1_meta_vld",   out_meta_valid, 1'b1);
        check("b1_meta",       out_meta_data, M1);
        check("b1_data",       out_pkt_data, mk(1));
        check("b1_eop",        out_pkt_eop, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 6'd0, mk(2));
        tick();
        check("b2_sop",        out_pkt_sop, 1'b0);
        check("b2_meta_vld",   out_meta_valid, 1'b0);
        check("b2_data",       out_pkt_data, mk(2));
        check("b2_meta",       out_meta_data, M1);
        beat(1'b1, 1'b0, 1'b1, 6'd5, mk(3));
        tick();
        check("b3_eop",        out_pkt_eop, 1'b1);
        check("b3_empty",      out_pkt_empty, 6'd5);
        check("b3_data",       out_pkt_data, mk(3));
        beat(1'b0, 1'b0, 1'b0, 6'd0, '0);
        tick();
        check("p1_drained",    out_pkt_valid, 1'b0);
        check("p1_pkt_cnt",    pkt_cnt, 32'd1);

        // ---- orphans ----
        beat(1'b1, 1'b0, 1'b0, 6'd0, mk(7));
        settle();
        check("orph_rdy",      in_pkt_ready, 1'b1);
        tick();
        beat(1'b1, 1'b0, 1'b1, 6'd1, mk(8));
        tick();
        beat(1'b0, 1'b0, 1'b0, 6'd0, '0);
        tick();
        check("orph_cnt",      orphan_cnt, 32'd2);
        check("orph_no_out",   out_pkt_valid, 1'b0);

        // ---- same-cycle meta and sop, then back-pressure ----
        meta(1'b1, M2);
        beat(1'b1, 1'b1, 1'b0, 6'd0, mk(4));
        settle();
        check("c0_meta_rdy",   in_meta_ready, 1'b1);
        check("c0_pkt_rdy",    in_pkt_ready, 1'b0);
        tick();
        meta(1'b0, '0);
        settle();
        check("c1_pkt_rdy",    in_pkt_ready, 1'b1);
        check("c1_no_out",     out_pkt_valid, 1'b0);
        tick();
        check("c2_sop",        out_pkt_sop, 1'b1);
        check("c2_data",       out_pkt_data, mk(4));
        check("c2_meta",       out_meta_data, M2);
        beat(1'b1, 1'b0, 1'b0, 6'd0, mk(5));
        out_pkt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_rdy",   in_pkt_ready, 1'b0);
            tick();
            check("stall_data",  out_pkt_data, mk(4));
            check("stall_sop",   out_pkt_sop, 1'b1);
            check("stall_valid", out_pkt_valid, 1'b1);
        end
        out_pkt_ready = 1'b1;
        settle();
        check("unstall_rdy",   in_pkt_ready, 1'b1);
        tick();
        check("s2_data",       out_pkt_data, mk(5));
        check("s2_sop",        out_pkt_sop, 1'b0);
        beat(1'b1, 1'b0, 1'b1, 6'd2, mk(6));
        tick();
        check("s3_data",       out_pkt_data, mk(6));
        check("s3_eop",        out_pkt_eop, 1'b1);
        check("s3_empty",      out_pkt_empty, 6'd2);
        beat(1'b0, 1'b0, 1'b0, 6'd0, '0);
        tick();
        check("s_drained",     out_pkt_valid, 1'b0);
        check("s_pkt_cnt",     pkt_cnt, 32'd2);

        // ---- oversize: 6 beats with MAX_BEATS=4 ----
        meta(1'b1, M3);
        tick();
        meta(1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, i == 0, i == 5, 6'd3, mk(10 + i));
            settle();
            check("ov_pkt_rdy",  in_pkt_ready, 1'b1);
            tick();
            if (i < 4) begin
                check("ov_valid",  out_pkt_valid, 1'b1);
                check("ov_data",   out_pkt_data, mk(10 + i));
                check("ov_sop",    out_pkt_sop, i == 0);
                check("ov_eop",    out_pkt_eop, i == 3);
                check("ov_empty",  out_pkt_empty, (i == 3) ? 6'd0 : 6'd3);
            end else begin
                check("ov_dropped", out_pkt_valid, 1'b0);
            end
        end
        beat(1'b0, 1'b0, 1'b0, 6'd0, '0);
        settle();
        check("ov_oversize",   oversize_cnt, 32'd1);
        check("ov_pkt_cnt",    pkt_cnt, 32'd3);
        check("ov_idle",       in_meta_ready, 1'b1);

        // ---- reset mid-packet ----
        meta(1'b1, M4);
        tick();
        meta(1'b0, '0);
        beat(1'b1, 1'b1, 1'b0, 6'd0, mk(20));
        tick();
        beat(1'b1, 1'b0, 1'b0, 6'd0, mk(21));
        tick();
        check("pre_rst_data",  out_pkt_data, mk(21));
        beat(1'b1, 1'b0, 1'b0, 6'd0, mk(22));
        rst_n = 1'b0;
        tick();
        check("mr_valid",      out_pkt_valid, 1'b0);
        check("mr_eop",        out_pkt_eop, 1'b0);
        check("mr_data",       out_pkt_data, '0);
        check("mr_meta",       out_meta_data, '0);
        check("mr_pkt_cnt",    pkt_cnt, 32'd0);
        check("mr_orphan",     orphan_cnt, 32'd0);
        check("mr_oversize",   oversize_cnt, 32'd0);
        check("mr_pkt_rdy",    in_pkt_ready, 1'b0);
        check("mr_meta_rdy",   in_meta_ready, 1'b0);
        rst_n = 1'b1;
        beat(1'b0, 1'b0, 1'b0, 6'd0, '0);
        meta(1'b1, M5);
        settle();
        check("mr_idle",       in_meta_ready, 1'b1);
        tick();
        meta(1'b0, '0);
        beat(1'b1, 1'b1, 1'b0, 6'd0, mk(30));
        tick();
        check("r1_sop",        out_pkt_sop, 1'b1);
        check("r1_meta",       out_meta_data, M5);
        check("r1_data",       out_pkt_data, mk(30));
        beat(1'b1, 1'b0, 1'b1, 6'd9, mk(31));
        tick();
        check("r2_eop",        out_pkt_eop, 1'b1);
        check("r2_empty",      out_pkt_empty, 6'd9);
        beat(1'b0, 1'b0, 1'b0, 6'd0, '0);
        tick();
        check("r_pkt_cnt",     pkt_cnt, 32'd1);
        check("r_orphan",      orphan_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
